cv32e40p_recovery_unit: RTL and testbench

- Sits beside cv32e40p_core and is the other end of the core's backup/recovery interface.
- Continuously shadows committed register-file writes and the backup PC/branch state that the core exports.
- On a recovery request it resets the core through setback, restores every shadowed register through the core's recovery write ports, then restarts fetch at the backed-up PC.
- Used by the fault-tolerant (lockstep/TMR) cluster integration.

---
 rtl/cv32e40p_recovery_unit.sv | 177 +++++++++++++++++
 tb/tb_cv32e40p_recovery_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_recovery_unit.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_recovery_unit
// Brief    : Shadows committed register-file writes and the backup PC/branch
//            state of cv32e40p_core. On request it sets the core back,
//            replays every shadowed register through the recovery write
//            ports, and then restarts fetch at the backed-up PC.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_recovery_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              recovery_req_i,
  input  logic              capture_en_i,
  input  logic              core_we_a_i,
  input  logic [ADDR_W-1:0] core_waddr_a_i,
  input  logic [31:0]       core_wdata_a_i,
  input  logic              core_we_b_i,
  input  logic [ADDR_W-1:0] core_waddr_b_i,
  input  logic [31:0]       core_wdata_b_i,
  input  logic [31:0]       backup_pc_i,
  input  logic              backup_branch_i,
  input  logic [31:0]       backup_branch_addr_i,
  output logic              setback_o,
  output logic              recover_o,
  output logic [ADDR_W-1:0] rf_waddr_a_o,
  output logic [31:0]       rf_wdata_a_o,
  output logic              rf_we_a_o,
  output logic [ADDR_W-1:0] rf_waddr_b_o,
  output logic [31:0]       rf_wdata_b_o,
  output logic              rf_we_b_o,
  output logic              pc_recover_o,
  output logic [31:0]       recovery_pc_o,
  output logic              recovery_branch_o,
  output logic [31:0]       recovery_branch_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]  c_num_regs = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0]  c_pair_step = (ADDR_W+1)'(2);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETBACK    = 3'd1,
    ST_RESTORE    = 3'd2,
    ST_PC_RECOVER = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  state_t            r_state;
  // Index of the next even register to replay; one bit wider so NUM_REGS fits.
  logic [ADDR_W:0]   r_idx;
  logic [31:0]       r_shadow [NUM_REGS];
  logic [31:0]       r_bk_pc;
  logic              r_bk_branch;
  logic [31:0]       r_bk_branch_addr;

  logic              w_capture;
  logic              w_wr_a;
  logic              w_wr_b;
  logic [IDX_W-1:0]  w_idx_a;
  logic [IDX_W-1:0]  w_idx_b;

  // Only IDLE shadows, so the core's own restore writes never loop back in.
  assign w_capture = (r_state == ST_IDLE) && capture_en_i;
  assign w_wr_a    = w_capture && core_we_a_i && (core_waddr_a_i != '0)
                     && ({1'b0, core_waddr_a_i} < c_num_regs);
  assign w_wr_b    = w_capture && core_we_b_i && (core_waddr_b_i != '0)
                     && ({1'b0, core_waddr_b_i} < c_num_regs);
  assign w_idx_a   = r_idx[IDX_W-1:0];
  assign w_idx_b   = w_idx_a | c_idx_one;

  // Shadow register file; port B is applied last so it wins an address clash.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else begin
      if (w_wr_a) r_shadow[core_waddr_a_i[IDX_W-1:0]] <= core_wdata_a_i;
      if (w_wr_b) r_shadow[core_waddr_b_i[IDX_W-1:0]] <= core_wdata_b_i;
    end
  end

  // PC/branch backup follows the core every cycle while capturing, else holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bk_pc          <= '0;
      r_bk_branch      <= 1'b0;
      r_bk_branch_addr <= '0;
    end else if (w_capture) begin
      r_bk_pc          <= backup_pc_i;
      r_bk_branch      <= backup_branch_i;
      r_bk_branch_addr <= backup_branch_addr_i;
    end
  end

  // Recovery sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state                <= ST_IDLE;
      r_idx                  <= '0;
      setback_o              <= 1'b0;
      recover_o              <= 1'b0;
      rf_waddr_a_o           <= '0;
      rf_wdata_a_o           <= '0;
      rf_we_a_o              <= 1'b0;
      rf_waddr_b_o           <= '0;
      rf_wdata_b_o           <= '0;
      rf_we_b_o              <= 1'b0;
      pc_recover_o           <= 1'b0;
      recovery_pc_o          <= '0;
      recovery_branch_o      <= 1'b0;
      recovery_branch_addr_o <= '0;
      busy_o                 <= 1'b0;
      done_o                 <= 1'b0;
    end else begin
      setback_o              <= 1'b0;
      recover_o              <= 1'b0;
      rf_waddr_a_o           <= '0;
      rf_wdata_a_o           <= '0;
      rf_we_a_o              <= 1'b0;
      rf_waddr_b_o           <= '0;
      rf_wdata_b_o           <= '0;
      rf_we_b_o              <= 1'b0;
      pc_recover_o           <= 1'b0;
      recovery_pc_o          <= '0;
      recovery_branch_o      <= 1'b0;
      recovery_branch_addr_o <= '0;
      busy_o                 <= 1'b0;
      done_o                 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (recovery_req_i) begin
            r_state   <= ST_SETBACK;
            setback_o <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        ST_SETBACK, ST_RESTORE: begin
          busy_o    <= 1'b1;
          recover_o <= 1'b1;
          if ((r_state == ST_RESTORE) && (r_idx == c_num_regs)) begin
            r_state                <= ST_PC_RECOVER;
            pc_recover_o           <= 1'b1;
            recovery_pc_o          <= r_bk_pc;
            recovery_branch_o      <= r_bk_branch;
            recovery_branch_addr_o <= r_bk_branch_addr;
          end else begin
            r_state      <= ST_RESTORE;
            rf_we_a_o    <= 1'b1;
            rf_we_b_o    <= 1'b1;
            rf_waddr_a_o <= r_idx[ADDR_W-1:0];
            rf_waddr_b_o <= {r_idx[ADDR_W-1:1], 1'b1};
            rf_wdata_a_o <= r_shadow[w_idx_a];
            rf_wdata_b_o <= r_shadow[w_idx_b];
            r_idx        <= r_idx + c_pair_step;
          end
        end
        ST_PC_RECOVER: begin
          r_state <= ST_DONE;
          done_o  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_recovery_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_recovery_unit
// Brief    : Directed self-checking bench for cv32e40p_recovery_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_recovery_unit;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 6;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              recovery_req_i;
  logic              capture_en_i;
  logic              core_we_a_i;
  logic [ADDR_W-1:0] core_waddr_a_i;
  logic [31:0]       core_wdata_a_i;
  logic              core_we_b_i;
  logic [ADDR_W-1:0] core_waddr_b_i;
  logic [31:0]       core_wdata_b_i;
  logic [31:0]       backup_pc_i;
  logic              backup_branch_i;
  logic [31:0]       backup_branch_addr_i;
  logic              setback_o;
  logic              recover_o;
  logic [ADDR_W-1:0] rf_waddr_a_o;
  logic [31:0]       rf_wdata_a_o;
  logic              rf_we_a_o;
  logic [ADDR_W-1:0] rf_waddr_b_o;
  logic [31:0]       rf_wdata_b_o;
  logic              rf_we_b_o;
  logic              pc_recover_o;
  logic [31:0]       recovery_pc_o;
  logic              recovery_branch_o;
  logic [31:0]       recovery_branch_addr_o;
  logic              busy_o;
  logic              done_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rf [NUM_REGS];

  always #5 clk = ~clk;

  cv32e40p_recovery_unit #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .recovery_req_i         (recovery_req_i),
    .capture_en_i           (capture_en_i),
    .core_we_a_i            (core_we_a_i),
    .core_waddr_a_i         (core_waddr_a_i),
    .core_wdata_a_i         (core_wdata_a_i),
    .core_we_b_i            (core_we_b_i),
    .core_waddr_b_i         (core_waddr_b_i),
    .core_wdata_b_i         (core_wdata_b_i),
    .backup_pc_i            (backup_pc_i),
    .backup_branch_i        (backup_branch_i),
    .backup_branch_addr_i   (backup_branch_addr_i),
    .setback_o              (setback_o),
    .recover_o              (recover_o),
    .rf_waddr_a_o           (rf_waddr_a_o),
    .rf_wdata_a_o           (rf_wdata_a_o),
    .rf_we_a_o              (rf_we_a_o),
    .rf_waddr_b_o           (rf_waddr_b_o),
    .rf_wdata_b_o           (rf_wdata_b_o),
    .rf_we_b_o              (rf_we_b_o),
    .pc_recover_o           (pc_recover_o),
    .recovery_pc_o          (recovery_pc_o),
    .recovery_branch_o      (recovery_branch_o),
    .recovery_branch_addr_o (recovery_branch_addr_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o)
  );

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, " setback"},    32'(setback_o),    32'd0);
    check({tag, " recover"},    32'(recover_o),    32'd0);
    check({tag, " we_a"},       32'(rf_we_a_o),    32'd0);
    check({tag, " we_b"},       32'(rf_we_b_o),    32'd0);
    check({tag, " pc_recover"}, 32'(pc_recover_o), 32'd0);
    check({tag, " rec_pc"},     recovery_pc_o,     32'd0);
    check({tag, " busy"},       32'(busy_o),       32'd0);
    check({tag, " done"},       32'(done_o),       32'd0);
  endtask

  // One cycle of port writes, presented at a falling edge.
  task automatic rf_write(input logic wa, input logic [ADDR_W-1:0] aa, input logic [31:0] da,
                          input logic wb, input logic [ADDR_W-1:0] ab, input logic [31:0] db);
    core_we_a_i = wa; core_waddr_a_i = aa; core_wdata_a_i = da;
    core_we_b_i = wb; core_waddr_b_i = ab; core_wdata_b_i = db;
    @(negedge clk);
    core_we_a_i = 1'b0; core_we_b_i = 1'b0;
  endtask

  // Pulse a request and walk the sequence cycle by cycle against exp_rf.
  // disturb_k >= 0 pokes a request and a core write in mid-restore;
  // abort_k >= 0 applies reset during that restore cycle.
  task automatic run_recovery(input string tag, input logic [31:0] epc, input logic ebr,
                              input logic [31:0] ebaddr, input int disturb_k, input int abort_k);
    int cyc;
    recovery_req_i = 1'b1;
    @(negedge clk);
    recovery_req_i = 1'b0;
    cyc = 1;
    check({tag, " setback"},      32'(setback_o), 32'd1);
    check({tag, " setback busy"}, 32'(busy_o),    32'd1);
    check({tag, " setback we"},   32'(rf_we_a_o), 32'd0);
    for (int k = 0; k < NUM_REGS / 2; k++) begin
      @(negedge clk);
      cyc++;
      check($sformatf("%s k=%0d we", tag, k), 32'({rf_we_a_o, rf_we_b_o, recover_o, busy_o}), 32'hF);
      check($sformatf("%s k=%0d addr_a", tag, k), 32'(rf_waddr_a_o), 32'(2 * k));
      check($sformatf("%s k=%0d data_a", tag, k), rf_wdata_a_o, exp_rf[2 * k]);
      check($sformatf("%s k=%0d addr_b", tag, k), 32'(rf_waddr_b_o), 32'(2 * k + 1));
      check($sformatf("%s k=%0d data_b", tag, k), rf_wdata_b_o, exp_rf[2 * k + 1]);
      check($sformatf("%s k=%0d setback", tag, k), 32'(setback_o), 32'd0);
      if (k == disturb_k) begin
        recovery_req_i = 1'b1;
        core_we_a_i = 1'b1; core_waddr_a_i = 6'd3; core_wdata_a_i = 32'h55;
      end
      if (k == disturb_k + 2) begin
        recovery_req_i = 1'b0;
        core_we_a_i = 1'b0;
      end
      if (k == abort_k) begin
        rst_i = 1'b1;
        @(negedge clk);
        check_all_quiet({tag, " abort"});
        rst_i = 1'b0;
        @(negedge clk);
        check_all_quiet({tag, " after abort"});
        return;
      end
    end
    @(negedge clk);
    cyc++;
    check({tag, " pc_recover"}, 32'(pc_recover_o),      32'd1);
    check({tag, " pc recover"}, 32'(recover_o),         32'd1);
    check({tag, " pc we"},      32'(rf_we_a_o | rf_we_b_o), 32'd0);
    check({tag, " pc busy"},    32'(busy_o),            32'd1);
    check({tag, " rec_pc"},     recovery_pc_o,          epc);
    check({tag, " rec_br"},     32'(recovery_branch_o), 32'(ebr));
    check({tag, " rec_braddr"}, recovery_branch_addr_o, ebaddr);
    @(negedge clk);
    cyc++;
    check({tag, " done"},       32'(done_o),       32'd1);
    check({tag, " latency"},    32'(cyc),          32'd19);
    check({tag, " done busy"},  32'(busy_o),       32'd0);
    check({tag, " done pcrec"}, 32'(pc_recover_o), 32'd0);
    check({tag, " done recpc"}, recovery_pc_o,     32'd0);
    @(negedge clk);
    check_all_quiet({tag, " post"});
    @(negedge clk);
    check_all_quiet({tag, " post2"});
  endtask

  initial begin
    rst_i = 1'b1; recovery_req_i = 1'b0; capture_en_i = 1'b1;
    core_we_a_i = 1'b0; core_waddr_a_i = '0; core_wdata_a_i = '0;
    core_we_b_i = 1'b0; core_waddr_b_i = '0; core_wdata_b_i = '0;
    backup_pc_i = '0; backup_branch_i = 1'b0; backup_branch_addr_i = '0;
    for (int i = 0; i < NUM_REGS; i++) exp_rf[i] = '0;
    repeat (3) @(negedge clk);
    check_all_quiet("reset");
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check_all_quiet("idle");

    // Empty shadow restores zeros and a zero PC.
    run_recovery("zeros", 32'h0, 1'b0, 32'h0, -1, -1);

    // Basic capture on both ports plus PC/branch backup.
    backup_pc_i = 32'h0000_1A40; backup_branch_i = 1'b1; backup_branch_addr_i = 32'h0000_1A80;
    rf_write(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b1, 6'd6, 32'h1234_5678);
    exp_rf[5] = 32'hDEAD_BEEF; exp_rf[6] = 32'h1234_5678;
    run_recovery("basic", 32'h0000_1A40, 1'b1, 32'h0000_1A80, -1, -1);

    // Port B wins on a same-address clash; x0 and out-of-range writes drop.
    backup_branch_i = 1'b0; backup_branch_addr_i = 32'h0;
    rf_write(1'b1, 6'd7, 32'h1, 1'b1, 6'd7, 32'h2);
    rf_write(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b1, 6'd40, 32'hCAFE_0000);
    exp_rf[7] = 32'h2;
    run_recovery("clash", 32'h0000_1A40, 1'b0, 32'h0, -1, -1);

    // Capture disabled freezes both shadow and PC backup.
    backup_pc_i = 32'h1000;
    rf_write(1'b1, 6'd9, 32'h99, 1'b0, 6'd0, 32'h0);
    exp_rf[9] = 32'h99;
    capture_en_i = 1'b0;
    backup_pc_i = 32'h2000;
    rf_write(1'b1, 6'd9, 32'hAA, 1'b0, 6'd0, 32'h0);
    run_recovery("frozen", 32'h1000, 1'b0, 32'h0, -1, -1);
    capture_en_i = 1'b1;

    // Request and core write in mid-restore are ignored; x3 stays 0.
    run_recovery("disturb", 32'h2000, 1'b0, 32'h0, 3, -1);
    run_recovery("after_disturb", 32'h2000, 1'b0, 32'h0, -1, -1);

    // Reset during restore aborts and clears everything.
    run_recovery("abort", 32'h2000, 1'b0, 32'h0, -1, 4);
    for (int i = 0; i < NUM_REGS; i++) exp_rf[i] = '0;
    backup_pc_i = 32'h0;
    @(negedge clk);
    run_recovery("post_reset", 32'h0, 1'b0, 32'h0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
